// File: rtl/onehot_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module   : onehot_mux_pipe
// Purpose  : N-way one-hot AND-OR selector with a registered valid/ready
//            output stage and illegal-select detection/counting.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_mux_pipe #(
    parameter int WIDTH     = 32,
    parameter int N         = 4,
    parameter int STRICT    = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_sel_err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 err_clr
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    localparam logic [N-1:0]         c_sel_one = N'(1);
    localparam logic [ERR_CNT_W-1:0] c_cnt_one = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] c_cnt_max = '1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [WIDTH-1:0]     r_data;
    logic                 r_sel_err;
    logic                 r_sticky;
    logic [ERR_CNT_W-1:0] r_count;

    logic [WIDTH-1:0]     w_sel_data;
    logic [WIDTH-1:0]     w_store_data;
    logic                 w_legal;
    logic                 w_accept;
    logic                 w_drain;
    logic                 w_err_evt;

    // AND-OR reduction: zero-hot gives 0, multi-hot gives the OR of picks.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            w_sel_data = w_sel_data | ({WIDTH{sel[k]}} & in_data[k*WIDTH +: WIDTH]);
        end
    end

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves 0.
    assign w_legal = (sel != '0) && ((sel & (sel - c_sel_one)) == '0);

    generate
        if (STRICT != 0) begin : g_strict_on
            assign w_store_data = w_legal ? w_sel_data : '0;
        end else begin : g_strict_off
            assign w_store_data = w_sel_data;
        end
    endgenerate

    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;
    assign w_err_evt = w_accept && !w_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL:  if (w_drain && !w_accept) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (r_state == S_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_sel_err <= 1'b0;
        end else if (w_accept) begin
            r_data    <= w_store_data;
            r_sel_err <= !w_legal;
        end
    end

    // A clear coinciding with an illegal accept still records that event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (err_clr) begin
            r_sticky <= w_err_evt;
            r_count  <= w_err_evt ? c_cnt_one : '0;
        end else if (w_err_evt) begin
            r_sticky <= 1'b1;
            if (r_count != c_cnt_max) begin
                r_count <= r_count + c_cnt_one;
            end
        end
    end

    assign out_data    = r_data;
    assign out_sel_err = r_sel_err;
    assign err_sticky  = r_sticky;
    assign err_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_onehot_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_mux_pipe
// Purpose  : Self-checking bench; three instances (default, STRICT=1,
//            ERR_CNT_W=2) share stimulus and are checked against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_mux_pipe;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic [3:0]   sel;
    logic         out_ready;
    logic         err_clr;

    wire [2:0]        o_ready;
    wire [2:0]        o_valid;
    wire [2:0][31:0]  o_data;
    wire [2:0]        o_serr;
    wire [2:0]        o_sticky;
    wire [2:0][7:0]   o_cnt;

    int n_cmp;
    int n_bad;

    // Reference model state; flow control is shared by all instances.
    logic        m_valid;
    logic [31:0] m_data   [3];
    logic        m_serr   [3];
    logic        m_sticky [3];
    int          m_cnt    [3];
    int          c_strict [3] = '{0, 1, 0};
    int          c_cmax   [3] = '{255, 255, 3};

    onehot_mux_pipe #(.WIDTH(32), .N(4), .STRICT(0), .ERR_CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[0]),
        .in_data(in_data), .sel(sel), .out_valid(o_valid[0]), .out_ready(out_ready),
        .out_data(o_data[0]), .out_sel_err(o_serr[0]), .err_sticky(o_sticky[0]),
        .err_count(o_cnt[0]), .err_clr(err_clr));

    onehot_mux_pipe #(.WIDTH(32), .N(4), .STRICT(1), .ERR_CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[1]),
        .in_data(in_data), .sel(sel), .out_valid(o_valid[1]), .out_ready(out_ready),
        .out_data(o_data[1]), .out_sel_err(o_serr[1]), .err_sticky(o_sticky[1]),
        .err_count(o_cnt[1]), .err_clr(err_clr));

    onehot_mux_pipe #(.WIDTH(32), .N(4), .STRICT(0), .ERR_CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[2]),
        .in_data(in_data), .sel(sel), .out_valid(o_valid[2]), .out_ready(out_ready),
        .out_data(o_data[2]), .out_sel_err(o_serr[2]), .err_sticky(o_sticky[2]),
        .err_count(o_cnt[2][1:0]), .err_clr(err_clr));

    assign o_cnt[2][7:2] = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_data[i] = '0; m_serr[i] = 1'b0; m_sticky[i] = 1'b0; m_cnt[i] = 0;
        end
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic cycle();
        logic        acc;
        logic        drn;
        logic        ill;
        logic [31:0] d;
        acc = in_valid && (!m_valid || out_ready);
        drn = m_valid && out_ready;
        ill = ($countones(sel) != 1);
        d = '0;
        for (int k = 0; k < 4; k++) if (sel[k]) d = d | in_data[k*32 +: 32];
        @(posedge clk);
        #1;
        if (acc) m_valid = 1'b1;
        else if (drn) m_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (acc) begin
                m_data[i] = (c_strict[i] != 0 && ill) ? 32'h0 : d;
                m_serr[i] = ill;
            end
            if (err_clr) begin
                m_cnt[i]    = (acc && ill) ? 1 : 0;
                m_sticky[i] = acc && ill;
            end else if (acc && ill) begin
                m_cnt[i]    = (m_cnt[i] + 1 > c_cmax[i]) ? c_cmax[i] : m_cnt[i] + 1;
                m_sticky[i] = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; sel = '0; out_ready = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({o_valid[i], o_data[i], o_serr[i], o_sticky[i], o_cnt[i]} !== '0) begin
                n_bad++;
                $display("FAIL reset_init inst%0d: got v=%b d=%h e=%b s=%b c=%0d want all 0",
                         i, o_valid[i], o_data[i], o_serr[i], o_sticky[i], o_cnt[i]);
            end
        end
        rst = 1'b0;
        in_valid = 1'b1; sel = 4'b0000; in_data = {32'h4, 32'h3, 32'h2, 32'h1};
        cycle();
        sel = 4'b0010;
        cycle();
        n_cmp++;
        if (o_valid[0] !== 1'b1 || o_ready[0] !== 1'b0 || o_sticky[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_prestall: got v=%b rdy=%b s=%b want v=1 rdy=0 s=1",
                     o_valid[0], o_ready[0], o_sticky[0]);
        end
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({o_valid[i], o_data[i], o_serr[i], o_sticky[i], o_cnt[i]} !== '0 || o_ready[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_async inst%0d: got v=%b d=%h e=%b s=%b c=%0d rdy=%b want 0s rdy=1",
                         i, o_valid[i], o_data[i], o_serr[i], o_sticky[i], o_cnt[i], o_ready[i]);
            end
        end
        model_reset();
        in_valid = 1'b0;
        #1 rst = 1'b0;
    endtask

    task automatic test_stream();
        in_data = {32'h4, 32'h3, 32'h2, 32'h1};
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel = 4'b0001 << k;
            #1;
            n_cmp++;
            if (o_ready[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_ready step%0d: got %b want 1", k, o_ready[0]);
            end
            cycle();
            n_cmp++;
            if (o_valid[0] !== 1'b1 || o_data[0] !== 32'(k + 1) || o_serr[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL stream_data step%0d: got v=%b d=%h e=%b want v=1 d=%h e=0",
                         k, o_valid[0], o_data[0], o_serr[0], k + 1);
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (o_cnt[0] !== 8'd0 || o_sticky[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_errcnt: got c=%0d s=%b want 0 0", o_cnt[0], o_sticky[0]);
        end
        cycle();
    endtask

    task automatic test_backpressure();
        in_data = {32'h4, 32'h3, 32'h2, 32'h1};
        in_valid = 1'b1; sel = 4'b0010; out_ready = 1'b1;
        cycle();
        sel = 4'b0100; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (o_ready[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_ready cyc%0d: got %b want 0", c, o_ready[0]);
            end
            cycle();
            n_cmp++;
            if (o_valid[0] !== 1'b1 || o_data[0] !== 32'h2) begin
                n_bad++;
                $display("FAIL bp_hold cyc%0d: got v=%b d=%h want v=1 d=2", c, o_valid[0], o_data[0]);
            end
        end
        out_ready = 1'b1;
        cycle();
        n_cmp++;
        if (o_valid[0] !== 1'b1 || o_data[0] !== 32'h3) begin
            n_bad++;
            $display("FAIL bp_release: got v=%b d=%h want v=1 d=3", o_valid[0], o_data[0]);
        end
        in_valid = 1'b0;
        cycle();
        n_cmp++;
        if (o_valid[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drain: got v=%b want 0", o_valid[0]);
        end
    endtask

    task automatic test_illegal();
        in_valid = 1'b0; err_clr = 1'b1; out_ready = 1'b1;
        cycle();
        err_clr = 1'b0;
        in_data = {32'h4000, 32'h300, 32'h0F, 32'hF0};
        in_valid = 1'b1; sel = 4'b0000;
        cycle();
        n_cmp++;
        if (o_data[0] !== 32'h0 || o_serr[0] !== 1'b1 || o_valid[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL ill_zerohot: got v=%b d=%h e=%b want v=1 d=0 e=1", o_valid[0], o_data[0], o_serr[0]);
        end
        sel = 4'b0011;
        cycle();
        n_cmp++;
        if (o_data[0] !== 32'hFF || o_serr[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL ill_multihot: got d=%h e=%b want d=ff e=1", o_data[0], o_serr[0]);
        end
        n_cmp++;
        if (o_cnt[0] !== 8'd2 || o_sticky[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL ill_count: got c=%0d s=%b want c=2 s=1", o_cnt[0], o_sticky[0]);
        end
        sel = 4'b0110;
        cycle();
        n_cmp++;
        if (o_data[1] !== 32'h0 || o_serr[1] !== 1'b1 || o_data[0] !== 32'h30F) begin
            n_bad++;
            $display("FAIL ill_strict: got strict d=%h e=%b legacy d=%h want strict d=0 e=1 legacy d=30f",
                     o_data[1], o_serr[1], o_data[0]);
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_saturation();
        in_valid = 1'b0; err_clr = 1'b1; out_ready = 1'b1;
        cycle();
        err_clr = 1'b0; in_valid = 1'b1; sel = 4'b0000;
        repeat (5) cycle();
        n_cmp++;
        if (o_cnt[2] !== 8'd3 || o_cnt[0] !== 8'd5) begin
            n_bad++;
            $display("FAIL sat_count: got w2=%0d w8=%0d want w2=3 w8=5", o_cnt[2], o_cnt[0]);
        end
        in_valid = 1'b0; err_clr = 1'b1;
        cycle();
        n_cmp++;
        if (o_cnt[2] !== 8'd0 || o_sticky[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_clr: got c=%0d s=%b want 0 0", o_cnt[2], o_sticky[2]);
        end
        in_valid = 1'b1; sel = 4'b1100;
        cycle();
        n_cmp++;
        if (o_cnt[2] !== 8'd1 || o_sticky[2] !== 1'b1 || o_cnt[0] !== 8'd1) begin
            n_bad++;
            $display("FAIL sat_clr_evt: got c=%0d s=%b w8=%0d want c=1 s=1 w8=1",
                     o_cnt[2], o_sticky[2], o_cnt[0]);
        end
        err_clr = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_idle_illegal();
        int snap;
        in_valid = 1'b1; sel = 4'b1000; out_ready = 1'b1;
        in_data = {32'h4, 32'h3, 32'h2, 32'h1};
        cycle();
        snap = m_cnt[0];
        in_valid = 1'b0; sel = 4'b0101; out_ready = 1'b0;
        repeat (10) cycle();
        n_cmp++;
        if (o_cnt[0] !== 8'(snap) || o_valid[0] !== 1'b1 || o_data[0] !== 32'h4) begin
            n_bad++;
            $display("FAIL idle_illegal: got c=%0d v=%b d=%h want c=%0d v=1 d=4",
                     o_cnt[0], o_valid[0], o_data[0], snap);
        end
        out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 19) == 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 9) < 7) sel = 4'b0001 << $urandom_range(0, 3);
            else sel = 4'($urandom);
            #1;
            n_cmp++;
            if (o_ready !== {3{!m_valid || out_ready}}) begin
                n_bad++;
                $display("FAIL rand_ready cyc%0d: got %b want %b", c, o_ready, {3{!m_valid || out_ready}});
            end
            cycle();
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (o_valid[i] !== m_valid || o_data[i] !== m_data[i] || o_serr[i] !== m_serr[i] ||
                    o_sticky[i] !== m_sticky[i] || o_cnt[i] !== 8'(m_cnt[i])) begin
                    n_bad++;
                    $display("FAIL rand cyc%0d inst%0d: got v=%b d=%h e=%b s=%b c=%0d want v=%b d=%h e=%b s=%b c=%0d",
                             c, i, o_valid[i], o_data[i], o_serr[i], o_sticky[i], o_cnt[i],
                             m_valid, m_data[i], m_serr[i], m_sticky[i], m_cnt[i]);
                end
            end
        end
        in_valid = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_illegal();
        test_saturation();
        test_idle_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onehot_mux_pipe.md
Name: onehot_mux_pipe

Overview:
- Parametrised successor to the datapath one-hot AND-OR selectors. N-way, WIDTH-bit, with a registered output stage and valid/ready handshake.
- Detects and counts illegal select codes: zero-hot or multi-hot.
- Sits between multi-cycle/pipelined datapath sources (ALU, memory, PC+4, immediate) and consumer stage registers.

Parameters:
- WIDTH, 32, data width of each input and the output.
- N, 4, number of inputs (2..16); select is N-bit one-hot.
- STRICT, 0, 0 = illegal select passes the AND-OR result through (legacy semantics); 1 = illegal select forces out_data to 0.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream presents data+select.
- in_ready  output  1  block can accept this cycle.
- in_data  input  N*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  N  one-hot select; bit k picks input k.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  registered selected data.
- out_sel_err  output  1  registered flag: the held result came from an illegal select.
- err_sticky  output  1  set by any accepted illegal select; cleared only by err_clr or rst.
- err_count  output  ERR_CNT_W  saturating count of accepted illegal selects.
- err_clr  input  1  synchronous clear of err_sticky and err_count.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - out_valid=0, out_data=0, out_sel_err=0, err_sticky=0, err_count=0.
  - Any held result is discarded.
- Output stage: single register, two states.
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready = !out_valid || out_ready. This is combinational; no combinational path from in_valid to out_*.
- Accept: in_valid && in_ready at an edge.
- Drain: out_valid && out_ready at an edge.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + drain, no accept -> EMPTY.
  - FULL + drain + accept -> FULL with new data. This gives back-to-back throughput of 1 per cycle.
  - FULL + !out_ready -> hold out_data/out_sel_err stable; in_ready=0.
- Latency: exactly 1 cycle from accept to out_valid.
- Select legality: legal iff sel has exactly one bit set.
- Selected data: bitwise OR over k of ({WIDTH{sel[k]}} & input k).
  - Zero-hot yields 0.
  - Multi-hot yields the OR of all selected inputs.
  - If STRICT=1 and the select is illegal, the stored data is 0.
- On accept:
  - out_data <= selected data.
  - out_sel_err <= !legal.
- err_count:
  - On accept with an illegal select, increment by 1, saturating at 2^ERR_CNT_W-1 (no wrap).
  - err_sticky <= 1 on the same event.
- err_clr:
  - Alone: err_count<=0, err_sticky<=0.
  - Same edge as an illegal accept: the new event is recorded, so err_count<=1, err_sticky<=1.
- in_valid=0 or in_ready=0: sel/in_data are ignored; no error is counted even if sel is illegal.
- Error handling never blocks flow; illegal transfers still produce out_valid.

Test Plan:
- Reset with out_valid=1 mid-stall (N=4, WIDTH=32): assert rst asynchronously between edges -> all outputs read 0 immediately, before the next edge.
- Streaming with out_ready=1: 4 accepts with in_data={D3..D0}={0x4,0x3,0x2,0x1} and sel=0001,0010,0100,1000 on consecutive cycles -> out_data=0x1,0x2,0x3,0x4 on the following 4 cycles, out_valid=1 throughout, in_ready stays 1, err_count=0.
- Backpressure: accept sel=0010 (out_data=0x2), then hold out_ready=0 for 3 cycles with a new in_valid -> in_ready=0, out_data stays 0x2. Release out_ready -> 0x2 drains and the pending input is accepted on the same edge.
- Illegal selects, STRICT=0: sel=0000 -> out_data=0, out_sel_err=1. sel=0011 with D0=0xF0, D1=0x0F -> out_data=0xFF, out_sel_err=1. Afterwards err_count=2, err_sticky=1.
- STRICT=1 with sel=0110 -> out_data=0, out_sel_err=1.
- Saturation and clear, ERR_CNT_W=2: 5 illegal accepts -> err_count=3. err_clr alone -> 0. err_clr on the same edge as an illegal accept -> err_count=1, err_sticky=1.
- Illegal sel with in_valid=0 for 10 cycles -> err_count unchanged, out_valid unchanged.
